// File: rtl/dm_dump_reader.sv
// Data-memory dump reader: takes over the data-memory read port, walks every
// word address and streams each word MSB-first as bytes to the UART TX block.
module dm_dump_reader #(
  parameter int DATA_SIZE     = 32,
  parameter int BYTE_SIZE     = 8,
  parameter int MEM_ADDR_SIZE = 5,
  parameter int MEMORY_SIZE   = 32
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic [DATA_SIZE-1:0]     i_read_dm,
  input  logic                     i_tx_done,
  output logic                     o_debug_unit_flag,
  output logic                     o_memory_data_enable,
  output logic                     o_memory_data_read_enable,
  output logic [MEM_ADDR_SIZE-1:0] o_memory_data_read_addr,
  output logic                     o_tx_start,
  output logic [BYTE_SIZE-1:0]     o_tx_data,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int NumBytes = DATA_SIZE / BYTE_SIZE;
  localparam int ByteIdxW = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam logic [MEM_ADDR_SIZE:0] LastAddr = (MEM_ADDR_SIZE + 1)'(MEMORY_SIZE - 1);
  localparam logic [ByteIdxW-1:0]    LastByte = ByteIdxW'(NumBytes - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLatch,
    StSend,
    StWaitTx,
    StDone
  } state_e;

  state_e                 state_q;
  logic [DATA_SIZE-1:0]   word_q;
  logic [MEM_ADDR_SIZE:0] addr_q;
  logic [ByteIdxW-1:0]    byte_q;
  logic                   flag_q;
  logic                   mem_en_q;
  logic                   tx_start_q;
  logic [BYTE_SIZE-1:0]   tx_data_q;
  logic                   busy_q;
  logic                   done_q;

  logic [ByteIdxW-1:0]    next_idx;
  logic [BYTE_SIZE-1:0]   next_byte;

  // Byte that follows the current one in the latched word, MSB byte first.
  assign next_idx = byte_q + 1'b1;

  always_comb begin
    next_byte = '0;
    for (int i = 0; i < NumBytes; i++) begin
      if (ByteIdxW'(i) == next_idx) begin
        next_byte = word_q[DATA_SIZE-1-i*BYTE_SIZE -: BYTE_SIZE];
      end
    end
  end

  // Outputs are loaded together with the state they belong to, so every
  // output is a flop and nothing depends combinationally on the inputs.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StIdle;
      word_q     <= '0;
      addr_q     <= '0;
      byte_q     <= '0;
      flag_q     <= 1'b0;
      mem_en_q   <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            addr_q   <= '0;
            byte_q   <= '0;
            flag_q   <= 1'b1;
            mem_en_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= StRead;
          end
        end
        StRead: begin
          state_q <= StLatch;
        end
        StLatch: begin
          word_q     <= i_read_dm;
          byte_q     <= '0;
          mem_en_q   <= 1'b0;
          tx_start_q <= 1'b1;
          tx_data_q  <= i_read_dm[DATA_SIZE-1 -: BYTE_SIZE];
          state_q    <= StSend;
        end
        StSend: begin
          state_q <= StWaitTx;
        end
        StWaitTx: begin
          if (i_tx_done) begin
            if (byte_q != LastByte) begin
              byte_q     <= next_idx;
              tx_start_q <= 1'b1;
              tx_data_q  <= next_byte;
              state_q    <= StSend;
            end else if (addr_q != LastAddr) begin
              addr_q   <= addr_q + 1'b1;
              mem_en_q <= 1'b1;
              state_q  <= StRead;
            end else begin
              flag_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_debug_unit_flag         = flag_q;
  assign o_memory_data_enable      = mem_en_q;
  assign o_memory_data_read_enable = mem_en_q;
  assign o_memory_data_read_addr   = addr_q[MEM_ADDR_SIZE-1:0];
  assign o_tx_start                = tx_start_q;
  assign o_tx_data                 = tx_data_q;
  assign o_busy                    = busy_q;
  assign o_done                    = done_q;

endmodule

// File: tb/tb_dm_dump_reader.sv
// Bench for dm_dump_reader: a timeline model of the dump protocol checked every
// cycle, plus a few hand-computed expectations for byte order and latency.
module tb_dm_dump_reader;

  localparam int DataSize = 32;
  localparam int ByteSize = 8;
  localparam int AddrSize = 5;
  localparam int MemSize  = 32;
  localparam int NumBytes = DataSize / ByteSize;

  logic                i_clock;
  logic                i_reset;
  logic                i_start;
  logic [DataSize-1:0] i_read_dm;
  logic                i_tx_done;
  logic                o_debug_unit_flag;
  logic                o_memory_data_enable;
  logic                o_memory_data_read_enable;
  logic [AddrSize-1:0] o_memory_data_read_addr;
  logic                o_tx_start;
  logic [ByteSize-1:0] o_tx_data;
  logic                o_busy;
  logic                o_done;

  logic startReq;
  logic startNoise;
  assign i_start = startReq | startNoise;

  dm_dump_reader #(
    .DATA_SIZE    (DataSize),
    .BYTE_SIZE    (ByteSize),
    .MEM_ADDR_SIZE(AddrSize),
    .MEMORY_SIZE  (MemSize)
  ) dut (
    .i_clock                  (i_clock),
    .i_reset                  (i_reset),
    .i_start                  (i_start),
    .i_read_dm                (i_read_dm),
    .i_tx_done                (i_tx_done),
    .o_debug_unit_flag        (o_debug_unit_flag),
    .o_memory_data_enable     (o_memory_data_enable),
    .o_memory_data_read_enable(o_memory_data_read_enable),
    .o_memory_data_read_addr  (o_memory_data_read_addr),
    .o_tx_start               (o_tx_start),
    .o_tx_data                (o_tx_data),
    .o_busy                   (o_busy),
    .o_done                   (o_done)
  );

  logic [DataSize-1:0] mem [MemSize];
  int assertCount = 0;
  int failCount   = 0;

  // Ack behaviour knobs and handshake between monitor and driver.
  int  ackDelay   = 1;
  bit  ackRandom  = 0;
  bit  ackHeld    = 0;
  bit  noiseOn    = 0;
  bit  sawStart   = 0;
  int  ackCnt     = 0;
  bit  lastRe     = 0;
  int  lastAddr   = 0;

  // Timeline model of the dump and observations of the DUT.
  int  cyc         = 0;
  bit  running     = 0;
  bit  waiting     = 0;
  bit  fresh       = 1;
  int  wordIdx     = 0;
  int  byteIdx     = 0;
  int  readCyc     = -10;
  int  nextSendCyc = -10;
  int  sendCyc     = -10;
  int  doneCyc     = -10;
  int  firstReadCyc = 0;
  int  doneCount   = 0;
  int  doneSeenCyc = 0;
  int  doneAddr    = 0;
  logic [ByteSize-1:0] heldByte = '0;
  logic [ByteSize-1:0] sentBytes [$];

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic checkZeroNow(input string tag);
    checkOutput({tag, "_flag"},     32'(o_debug_unit_flag), 0);
    checkOutput({tag, "_mem_en"},   32'(o_memory_data_enable), 0);
    checkOutput({tag, "_read_en"},  32'(o_memory_data_read_enable), 0);
    checkOutput({tag, "_addr"},     32'(o_memory_data_read_addr), 0);
    checkOutput({tag, "_tx_start"}, 32'(o_tx_start), 0);
    checkOutput({tag, "_tx_data"},  32'(o_tx_data), 0);
    checkOutput({tag, "_busy"},     32'(o_busy), 0);
    checkOutput({tag, "_done"},     32'(o_done), 0);
  endtask

  // Compare process: outputs of the cycle are sampled on the falling edge,
  // together with the inputs the DUT will see at the next rising edge.
  initial begin
    logic [DataSize-1:0] shifted;
    bit expRead, expSend, expDone;
    forever begin
      @(negedge i_clock);
      cyc++;
      lastRe   = o_memory_data_read_enable;
      lastAddr = int'(o_memory_data_read_addr);
      if (o_tx_start) sawStart = 1;
      if (o_done) begin
        doneCount++;
        doneSeenCyc = cyc;
        doneAddr    = int'(o_memory_data_read_addr);
      end
      if (i_reset) begin
        checkZeroNow("in_reset");
        running = 0;
        waiting = 0;
        fresh   = 1;
        doneCyc = -10;
      end else begin
        expRead = running && (cyc == readCyc || cyc == readCyc + 1);
        expSend = running && (cyc == nextSendCyc);
        expDone = running && (cyc == doneCyc);
        checkOutput("busy",     32'(o_busy), 32'(running));
        checkOutput("done",     32'(o_done), 32'(expDone));
        checkOutput("flag",     32'(o_debug_unit_flag), 32'(running && !expDone));
        checkOutput("mem_en",   32'(o_memory_data_enable), 32'(expRead));
        checkOutput("read_en",  32'(o_memory_data_read_enable), 32'(expRead));
        checkOutput("tx_start", 32'(o_tx_start), 32'(expSend));
        if (running) begin
          checkOutput("addr", 32'(o_memory_data_read_addr), 32'(wordIdx));
        end else if (fresh) begin
          checkOutput("idle_addr", 32'(o_memory_data_read_addr), 0);
          checkOutput("idle_data", 32'(o_tx_data), 0);
        end
        if (expSend) begin
          shifted  = mem[wordIdx] >> (ByteSize * (NumBytes - 1 - byteIdx));
          heldByte = shifted[ByteSize-1:0];
          checkOutput("tx_data", 32'(o_tx_data), 32'(heldByte));
          sentBytes.push_back(heldByte);
          waiting = 1;
          sendCyc = cyc;
        end else if (waiting) begin
          checkOutput("tx_hold", 32'(o_tx_data), 32'(heldByte));
        end
        if (expDone) begin
          running = 0;
        end else if (!running) begin
          if (i_start) begin
            running      = 1;
            fresh        = 0;
            waiting      = 0;
            wordIdx      = 0;
            byteIdx      = 0;
            readCyc      = cyc + 1;
            nextSendCyc  = cyc + 3;
            doneCyc      = -10;
            firstReadCyc = cyc + 1;
          end
        end else if (waiting && cyc > sendCyc && i_tx_done) begin
          waiting = 0;
          if (byteIdx < NumBytes - 1) begin
            byteIdx++;
            nextSendCyc = cyc + 1;
          end else if (wordIdx < MemSize - 1) begin
            wordIdx++;
            byteIdx     = 0;
            readCyc     = cyc + 1;
            nextSendCyc = cyc + 3;
          end else begin
            doneCyc = cyc + 1;
          end
        end
      end
    end
  end

  // UART ack, random hazards and a one-cycle-latency memory behind the read port.
  initial begin
    i_tx_done  = 1'b0;
    startNoise = 1'b0;
    i_read_dm  = '0;
    forever begin
      @(posedge i_clock);
      #2;
      if (i_reset) begin
        sawStart = 0;
        ackCnt   = 0;
      end else if (sawStart) begin
        sawStart = 0;
        ackCnt   = 1;
        if (ackRandom) ackDelay = $urandom_range(1, 4);
      end else if (ackCnt != 0) begin
        ackCnt++;
      end
      i_tx_done  = ackHeld || (ackCnt != 0 && ackCnt == ackDelay) ||
                   (noiseOn && $urandom_range(0, 4) == 0);
      startNoise = noiseOn && o_busy && ($urandom_range(0, 5) == 0);
      if (lastRe) i_read_dm = mem[lastAddr];
      else        i_read_dm = $urandom;
    end
  end

  task automatic waitDone(input int budget);
    int startDone = doneCount;
    int n = 0;
    while (doneCount == startDone && n < budget) begin
      @(negedge i_clock);
      #1;
      n++;
    end
    checkOutput("dump_finished", 32'(doneCount - startDone), 1);
  endtask

  task automatic applyStimulus(input int delay, input bit rnd, input bit held, input bit noise);
    ackDelay  = delay;
    ackRandom = rnd;
    ackHeld   = held;
    noiseOn   = noise;
    sentBytes.delete();
    @(posedge i_clock);
    #2 startReq = 1'b1;
    @(posedge i_clock);
    #2 startReq = 1'b0;
    waitDone(6000);
    noiseOn = 0;
    ackHeld = 0;
    repeat (3) @(negedge i_clock);
    #1;
    checkOutput("byte_count", 32'(sentBytes.size()), 128);
  endtask

  initial begin
    int savedDone;
    int n;
    i_reset  = 1'b1;
    startReq = 1'b0;
    for (int k = 0; k < MemSize; k++) mem[k] = 32'(k) * 32'h0101_0101;
    mem[0] = 32'h1122_3344;
    mem[1] = 32'hA5A5_0001;

    // Reset asserted mid-cycle, then a quiet idle period.
    repeat (2) @(posedge i_clock);
    #2 i_reset = 1'b0;
    @(negedge i_clock);
    #3 i_reset = 1'b1;
    #1 checkZeroNow("async_reset");
    @(posedge i_clock);
    #2 i_reset = 1'b0;
    repeat (20) @(negedge i_clock);

    // Byte order and full-dump latency with immediate acks.
    applyStimulus(1, 0, 0, 0);
    if (sentBytes.size() >= 128) begin
      checkOutput("order0", 32'(sentBytes[0]), 32'h11);
      checkOutput("order1", 32'(sentBytes[1]), 32'h22);
      checkOutput("order2", 32'(sentBytes[2]), 32'h33);
      checkOutput("order3", 32'(sentBytes[3]), 32'h44);
      checkOutput("order4", 32'(sentBytes[4]), 32'hA5);
      checkOutput("order5", 32'(sentBytes[5]), 32'hA5);
      checkOutput("order6", 32'(sentBytes[6]), 32'h00);
      checkOutput("order7", 32'(sentBytes[7]), 32'h01);
      checkOutput("order_last", 32'(sentBytes[127]), 32'h1F);
    end
    checkOutput("done_latency", 32'(doneSeenCyc - firstReadCyc + 1), 321);
    checkOutput("done_addr", 32'(doneAddr), 31);

    // Slow UART, random words.
    for (int k = 0; k < MemSize; k++) mem[k] = $urandom;
    applyStimulus(15, 0, 0, 0);

    // Random ack delays with stray start/ack pulses.
    for (int k = 0; k < MemSize; k++) mem[k] = $urandom;
    applyStimulus(1, 1, 0, 1);

    // Ack held high: still one start pulse per byte, minimum latency.
    applyStimulus(1, 0, 1, 0);
    checkOutput("held_latency", 32'(doneSeenCyc - firstReadCyc + 1), 321);

    // Reset during WAIT_TX of word 7 byte 2, then a fresh dump.
    mem[0]    = 32'h1122_3344;
    ackDelay  = 15;
    ackRandom = 0;
    sentBytes.delete();
    savedDone = doneCount;
    @(posedge i_clock);
    #2 startReq = 1'b1;
    @(posedge i_clock);
    #2 startReq = 1'b0;
    n = 0;
    while (sentBytes.size() < 31 && n < 3000) begin
      @(negedge i_clock);
      #1;
      n++;
    end
    checkOutput("reach_word7_byte2", 32'(sentBytes.size()), 31);
    repeat (3) @(negedge i_clock);
    #3 i_reset = 1'b1;
    #1 checkZeroNow("mid_dump_reset");
    repeat (2) @(posedge i_clock);
    #2 i_reset = 1'b0;
    repeat (40) @(negedge i_clock);
    #1 checkOutput("no_done_after_abort", 32'(doneCount), 32'(savedDone));
    applyStimulus(1, 0, 0, 0);
    if (sentBytes.size() > 0) checkOutput("restart_first_byte", 32'(sentBytes[0]), 32'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
